// File: rtl/sid_audio_decim.sv
// sid_audio_decim
//   Box-car decimator behind the SID filter/volume stage. A phase
//   accumulator closes frames of fractional length (OUT_MOD/OUT_INC
//   samples on average). Each frame sum is divided by its sample count
//   using a 24-step restoring divider. Results go into a 4-entry
//   show-ahead FIFO.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high
//   sample_ce  audio_in valid strobe (>= 27 clocks apart)
//   audio_in   signed 18-bit filter sample
//   out_data   signed 18-bit FIFO head (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accept; pop on out_valid & out_ready
//   out_level  FIFO occupancy 0..4
//   overrun    sticky: a frame was lost (busy divider or full FIFO)
module sid_audio_decim #(
   parameter int unsigned OUT_INC = 48000,
   parameter int unsigned OUT_MOD = 985248
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_ce,
   input  logic signed [17:0] audio_in,
   output logic signed [17:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2:0]         out_level,
   output logic               overrun
);

   localparam logic [20:0] INC = 21'(OUT_INC);
   localparam logic [20:0] MOD = 21'(OUT_MOD);

   typedef enum logic [1:0] {IDLE, DIV, WRITE} state_t;

   // ---------------- phase / frame accumulation ----------------
   logic [20:0]        phase, phase_sum;
   logic               dump;
   logic signed [23:0] acc, frame_sum;
   logic [23:0]        frame_abs;
   logic [5:0]         cnt, frame_cnt;

   assign phase_sum = phase + INC;
   assign dump      = sample_ce && (phase_sum >= MOD);
   // The closing sample belongs to the frame being dumped.
   assign frame_sum = acc + {{6{audio_in[17]}}, audio_in};
   assign frame_cnt = cnt + 6'd1;
   assign frame_abs = frame_sum[23] ? 24'(-frame_sum) : 24'(frame_sum);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (sample_ce) begin
         if (dump) begin
            phase <= phase_sum - MOD;
            acc   <= '0;
            cnt   <= '0;
         end else begin
            phase <= phase_sum;
            acc   <= frame_sum;
            cnt   <= frame_cnt;
         end
      end
   end

   // ---------------- control FSM ----------------
   state_t      state, state_nxt;
   logic [4:0]  iter;
   logic [23:0] quo;       // dividend shifts out MSB-first, quotient shifts in
   logic [6:0]  rem;
   logic [5:0]  divisor;
   logic        neg;
   logic [6:0]  trial;
   logic        ge;

   assign trial = {rem[5:0], quo[23]};
   assign ge    = trial >= {1'b0, divisor};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (dump) state_nxt = DIV;
         DIV:     if (iter == 5'd23) state_nxt = WRITE;
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iter    <= '0;
         quo     <= '0;
         rem     <= '0;
         divisor <= '0;
         neg     <= 1'b0;
      end else if (state == IDLE && dump) begin
         iter    <= '0;
         quo     <= frame_abs;
         rem     <= '0;
         divisor <= frame_cnt;
         neg     <= frame_sum[23];
      end else if (state == DIV) begin
         iter <= iter + 5'd1;
         quo  <= {quo[22:0], ge};
         rem  <= ge ? trial - {1'b0, divisor} : trial;
      end
   end

   // |average| <= 2^17, so the 18-bit negate covers -131072 exactly.
   logic [17:0] result;
   assign result = neg ? 18'(-quo[17:0]) : quo[17:0];

   // ---------------- output FIFO ----------------
   logic [17:0] mem [4];
   logic [1:0]  wptr, rptr;
   logic        push, pop, full, accept;

   assign push      = (state == WRITE);
   assign pop       = out_valid && out_ready;
   assign full      = (out_level == 3'd4);
   assign accept    = push && (!full || pop);
   assign out_valid = (out_level != 3'd0);
   assign out_data  = out_valid ? $signed(mem[rptr]) : 18'sd0;

   always_ff @(posedge clk) begin
      if (accept) mem[wptr] <= result;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         out_level <= '0;
         overrun   <= 1'b0;
      end else begin
         if (accept) wptr <= wptr + 2'd1;
         if (pop)    rptr <= rptr + 2'd1;
         case ({accept, pop})
            2'b10:   out_level <= out_level + 3'd1;
            2'b01:   out_level <= out_level - 3'd1;
            default: out_level <= out_level;
         endcase
         if ((dump && state != IDLE) || (push && !accept)) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sid_audio_decim.sv
// Directed bench for sid_audio_decim: a 4-sample-frame instance carries the
// table vectors, latency, backpressure and reset cases; a 3/10 instance
// covers fractional frame lengths (counts 4,3,3).
module tb_sid_audio_decim;

   logic               clk = 1'b0;
   logic               reset;
   logic               sample_ce, frac_en;
   logic signed [17:0] audio_in;
   logic               main_ce, frac_ce;

   logic signed [17:0] out_data, frac_data;
   logic               out_valid, frac_valid;
   logic               out_ready, frac_ready;
   logic [2:0]         out_level, frac_level;
   logic               overrun, frac_overrun;

   int checks = 0;
   int errors = 0;

   assign main_ce = sample_ce & ~frac_en;
   assign frac_ce = sample_ce & frac_en;

   always #5 clk = ~clk;

   sid_audio_decim #(.OUT_INC(1), .OUT_MOD(4)) u_dut (
      .clk(clk), .reset(reset), .sample_ce(main_ce), .audio_in(audio_in),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_level(out_level), .overrun(overrun));

   sid_audio_decim #(.OUT_INC(3), .OUT_MOD(10)) u_frac (
      .clk(clk), .reset(reset), .sample_ce(frac_ce), .audio_in(audio_in),
      .out_data(frac_data), .out_valid(frac_valid), .out_ready(frac_ready),
      .out_level(frac_level), .overrun(frac_overrun));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one strobe; returns at the negedge just after the sampling edge.
   task automatic send(input int v);
      @(negedge clk);
      audio_in  = 18'(v);
      sample_ce = 1'b1;
      @(negedge clk);
      sample_ce = 1'b0;
   endtask

   task automatic gap();
      repeat (28) @(negedge clk);
   endtask

   // Cycles from the dump edge until out_valid is seen (60 = timeout).
   task automatic wait_valid(output int k);
      k = 0;
      while (!out_valid && k < 60) begin
         @(negedge clk);
         k++;
      end
   endtask

   // Fractional instance: drained every cycle, checked against a queue.
   int frac_exp[$];
   always @(negedge clk) begin
      if (!reset && frac_valid) begin
         if (frac_exp.size() == 0) chk("frac_unexpected", int'(frac_data), 0);
         else                      chk("frac_data", int'(frac_data), frac_exp.pop_front());
      end
   end

   typedef struct {
      int s [4];
      int exp;
   } vec_t;

   vec_t vecs [10];

   task automatic set_vec(input int i, input int a, input int b, input int c,
                          input int d, input int e);
      vecs[i].s[0] = a; vecs[i].s[1] = b; vecs[i].s[2] = c; vecs[i].s[3] = d;
      vecs[i].exp  = e;
   endtask

   initial begin
      int k;

      set_vec(0,    1000,    1000,    1000,    1000,    1000);
      set_vec(1,       0,       1,       2,       3,       1);
      set_vec(2,      -1,      -2,      -3,      -4,      -2);
      set_vec(3, -131072, -131072, -131072, -131072, -131072);
      set_vec(4,  131071,  131071,  131071,  131071,  131071);
      set_vec(5,       5,      -5,       7,       0,       1);
      set_vec(6,      -7,       0,       0,       0,      -1);
      set_vec(7,       3,       0,       0,       0,       0);
      set_vec(8,     100,     200,     300,     401,     250);
      set_vec(9,    -100,    -200,    -300,    -401,    -250);

      reset = 1'b1; sample_ce = 1'b0; frac_en = 1'b0; audio_in = '0;
      out_ready = 1'b0; frac_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data",  int'(out_data), 0);
      chk("rst_level", int'(out_level), 0);
      chk("rst_overrun", int'(overrun), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // ---- table: one 4-sample frame per vector ----
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < 4; j++) begin
            send(vecs[i].s[j]);
            if (j < 3) gap();
         end
         wait_valid(k);
         chk("latency", k, 25);
         chk("avg", int'(out_data), vecs[i].exp);
         chk("level_one", int'(out_level), 1);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk("pop_empty", int'(out_valid), 0);
         repeat (5) @(negedge clk);
      end
      chk("no_overrun", int'(overrun), 0);

      // ---- backpressure: 5 frames, no consumer ----
      for (int f = 0; f < 5; f++) begin
         for (int j = 0; j < 4; j++) begin
            send((f + 1) * 10);
            gap();
         end
         if (f == 3) begin
            chk("bp_level4", int'(out_level), 4);
            chk("bp_no_ovr", int'(overrun), 0);
         end
      end
      chk("bp_level_full", int'(out_level), 4);
      chk("bp_overrun", int'(overrun), 1);
      out_ready = 1'b1;
      for (int e = 0; e < 4; e++) begin
         chk("drain_valid", int'(out_valid), 1);
         chk("drain_data", int'(out_data), (e + 1) * 10);
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("drain_done", int'(out_valid), 0);
      chk("drain_level", int'(out_level), 0);

      // ---- reset 10 clocks into a division ----
      for (int j = 0; j < 4; j++) begin
         send(77);
         if (j < 3) gap();
      end
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_data", int'(out_data), 0);
      chk("mid_rst_level", int'(out_level), 0);
      chk("mid_rst_overrun", int'(overrun), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("no_stale", int'(out_valid), 0);
      for (int j = 0; j < 4; j++) begin
         send(j + 1);
         if (j < 3) gap();
      end
      wait_valid(k);
      chk("post_rst_lat", k, 25);
      chk("post_rst_avg", int'(out_data), 2);
      chk("post_rst_ovr", int'(overrun), 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // ---- fractional rate 3/10: frame counts 4,3,3 ----
      frac_exp.push_back(2);   // (1+2+3+4)/4
      frac_exp.push_back(6);   // (5+6+7)/3
      frac_exp.push_back(9);   // (8+9+10)/3
      repeat (6) frac_exp.push_back(500);
      frac_en = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         send(j <= 10 ? j : 500);
         gap();
      end
      frac_en = 1'b0;
      repeat (10) @(negedge clk);
      chk("frac_count_left", frac_exp.size(), 0);
      chk("frac_overrun", int'(frac_overrun), 0);
      chk("main_untouched", int'(out_level), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/sid_audio_decim.md
# sid_audio_decim

Sample-rate decimator and output buffer that sits directly downstream of the SID filter/volume stage. Consumes the filter's 18-bit audio word once per SID cycle and box-car averages it over fractional-length frames set by a phase accumulator (e.g. ~985 kHz to 48 kHz). Normalises each frame sum with a sequential divider and queues the results in a 4-entry show-ahead FIFO with a valid/ready handshake toward the audio mixer/serialiser.

## Interface
- OUT_INC, 48000: phase increment per input sample; 1 ≤ OUT_INC ≤ OUT_MOD.
- OUT_MOD, 985248: phase modulus; OUT_MOD < 2^20 and ceil(OUT_MOD/OUT_INC) ≤ 63.
- clk  in  1  system clock; one clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- sample_ce  in  1  strobe; audio_in is valid on this cycle. Never asserted on consecutive cycles; at least 27 clocks apart.
- audio_in  in  18  signed filter output sample.
- out_data  out  18  signed averaged sample at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- out_level  out  3  FIFO occupancy, 0..4.
- overrun  out  1  sticky; a frame was lost. Cleared only by reset.

## Operation
- Phase: 21-bit unsigned. On sample_ce compute p = phase + OUT_INC.
  - If p ≥ OUT_MOD: phase ← p − OUT_MOD and a dump occurs.
  - Otherwise phase ← p.
- Accumulator: 24-bit signed acc and 6-bit cnt.
  - On sample_ce without dump: acc += sign-extended audio_in; cnt += 1.
  - On dump: the current sample is included in the closing frame. Frame sum = acc + audio_in, frame count = cnt + 1, so count ≥ 1 always. acc ← 0, cnt ← 0.
- Control FSM, states IDLE, DIV, WRITE:
  - IDLE: on dump, latch |sum| (24-bit unsigned), sign, and count → DIV.
  - DIV: 24-iteration restoring division of |sum| by count, one quotient bit per clock MSB-first, 7-bit partial remainder → WRITE after 24th clock.
  - WRITE: result = sign ? −quotient : quotient, truncated toward zero, taken as 18 bits (always in range). Push into FIFO → IDLE.
- Dump while FSM not IDLE: the frame is discarded and overrun ← 1. Accumulator still restarts.
- FIFO: 4 entries, show-ahead.
  - out_data = head entry; out_data = 0 when empty.
  - Pop when out_valid & out_ready.
  - A push in WRITE is accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the result is dropped and overrun ← 1.
  - Simultaneous push and pop leaves out_level unchanged.
- Reset (any time, including mid-division): phase, acc, cnt, FIFO pointers and level → 0; FSM → IDLE; out_valid = 0, out_data = 0, out_level = 0, overrun = 0. Any in-flight frame is lost without setting overrun.

## Timing
- Dump at clock edge T (sample_ce high in cycle before T): the FSM enters DIV at T. DIV occupies cycles T..T+23, WRITE is cycle T+24, and the push occurs at edge T+25.
- If the FIFO was empty, out_valid rises and out_data is valid in cycle T+25, i.e. 25 clocks after the dump edge.
- Pop takes effect at the edge where out_valid & out_ready; the next entry is presented in the following cycle.
- out_level and out_valid are registered and update on the same edge as the push or pop.
- The sample_ce spacing of ≥ 27 clocks guarantees no DIV overlap for legal parameters. The overrun path covers misuse.

## Test plan
- Constant input, OUT_INC=1, OUT_MOD=4, audio_in=1000, out_ready=1 → one output per 4 samples, each 1000; out_valid first rises 25 clocks after the 4th sample's edge.
- Rounding, OUT_INC=1, OUT_MOD=4:
  - Inputs 0,1,2,3 → output 1.
  - Inputs −1,−2,−3,−4 → output −2 (truncation toward zero).
- Extremes, OUT_INC=1, OUT_MOD=63:
  - Constant −131072 → output −131072.
  - Constant 131071 → output 131071.
  - No overrun in either case.
- Fractional rate, default parameters, 985248 samples of constant 500 → exactly 48000 outputs, all 500. Every frame count is 20 or 21.
- Backpressure, OUT_INC=1, OUT_MOD=2, out_ready=0, 5 frames:
  - After 4 frames: out_level=4.
  - On the 5th result: dropped, overrun=1.
  - Then out_ready=1: the 4 stored values drain in order; out_valid falls after the last.
- Reset mid-DIV (assert 10 clocks after a dump):
  - During reset: all outputs 0, out_valid=0, overrun=0.
  - After release: the next full frame produces a correct average.
